// File: rtl/serial_char_tx.sv
// serial_char_tx: async-serial frame transmitter (start 0, DATA_BITS data LSB first, stop 1).
// Latency: start bit on serialOut right after the accepting edge; a frame takes (DATA_BITS+2)*CLKS_PER_BIT cycles.
// Backpressure: loadChar is accepted only in IDLE or on the frame's final edge; at any other edge it is ignored.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   loadChar   request to send parallelIn
//   parallelIn character to transmit, captured when the load is accepted
//   serialOut  registered serial line, idle high
//   txBusy     high while a frame is in progress
//   charSent   one-cycle pulse on the edge that completes a frame
module serial_char_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 loadChar,
  input  logic [DATA_BITS-1:0] parallelIn,
  output logic                 serialOut,
  output logic                 txBusy,
  output logic                 charSent
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 sent_q, sent_d;
  logic                 div_wrap;

  // Last clock of the current bit period.
  assign div_wrap = (div_q == DIV_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      sent_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      sent_q   <= sent_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    div_d   = div_wrap ? '0 : div_q + DIV_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        // Divider is parked at zero so the start bit gets a full period.
        div_d = '0;
        if (loadChar) begin
          state_d = START;
          shift_d = parallelIn;
          bit_d   = '0;
        end
      end
      START: begin
        if (div_wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (div_wrap) begin
          // Data bit 0 is already in shift_q[0]; each later bit arrives by shifting.
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (div_wrap) begin
          // A load on the completion edge chains straight into the next start bit.
          if (loadChar) begin
            state_d = START;
            shift_d = parallelIn;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: the line level is decoded from the next state and registered,
  // so serialOut is a clean flop output with no path from loadChar/parallelIn.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
    sent_d = (state_q == STOP) && div_wrap;
  end

  assign serialOut = serial_q;
  assign txBusy    = (state_q != IDLE);
  assign charSent  = sent_q;

endmodule

// File: tb/tb_serial_char_tx.sv
// tb_serial_char_tx: directed self-checking bench for serial_char_tx.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: loads during a frame are driven deliberately to confirm they are ignored.
module tb_serial_char_tx;

  logic       clk;
  logic       rst;
  logic       loadChar;
  logic [7:0] parallelIn;
  logic       serialOut;
  logic       txBusy;
  logic       charSent;

  logic       loadChar7;
  logic [6:0] parallelIn7;
  logic       serialOut7;
  logic       txBusy7;
  logic       charSent7;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  serial_char_tx dut (
    .clk        (clk),
    .rst        (rst),
    .loadChar   (loadChar),
    .parallelIn (parallelIn),
    .serialOut  (serialOut),
    .txBusy     (txBusy),
    .charSent   (charSent)
  );

  serial_char_tx #(.DATA_BITS(7), .CLKS_PER_BIT(4)) dut7 (
    .clk        (clk),
    .rst        (rst),
    .loadChar   (loadChar7),
    .parallelIn (parallelIn7),
    .serialOut  (serialOut7),
    .txBusy     (txBusy7),
    .charSent   (charSent7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe one default-parameter frame starting just after its accepting edge E.
  // Drives loadChar (held or pulsed at edge offsets p1/p2) and parallelIn meanwhile.
  // Returns just after edge E+160.
  task automatic run_frame(input int p1, input int p2, input logic hold,
                           input logic [7:0] busy_data,
                           output logic [9:0] bits, output int busy_cyc,
                           output int sent_cnt, output int glitches);
    logic bit_start;
    bits      = '0;
    busy_cyc  = 0;
    sent_cnt  = 0;
    glitches  = 0;
    bit_start = 1'b1;
    for (int c = 0; c < 160; c++) begin
      if (c % 16 == 0) bit_start = serialOut;
      else if (serialOut !== bit_start) glitches++;
      if (c % 16 == 8) bits[c/16] = serialOut;
      if (txBusy === 1'b1) busy_cyc++;
      if (charSent === 1'b1) sent_cnt++;
      loadChar   = hold || (c + 1 == p1) || (c + 1 == p2);
      parallelIn = busy_data;
      tick();
    end
  endtask

  logic [9:0] bits;
  logic [8:0] bits7;
  int busy_cyc, sent_cnt, glitches, t_first, extra;
  logic b7_start;

  initial begin
    // 1. Reset hold with a load pending
    rst = 1'b0; loadChar = 1'b1; parallelIn = 8'hFF;
    loadChar7 = 1'b0; parallelIn7 = 7'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_serialOut", serialOut, 1);
      check("rst_txBusy",    txBusy,    0);
      check("rst_charSent",  charSent,  0);
    end
    rst = 1'b1; loadChar = 1'b0;
    tick();
    check("idle_serialOut", serialOut, 1);
    check("idle_txBusy",    txBusy,    0);

    // 2. Single frame 0xA5; parallelIn changes after capture
    parallelIn = 8'hA5; loadChar = 1'b1;
    tick();
    check("t2_start_level", serialOut, 0);
    check("t2_start_busy",  txBusy,    1);
    run_frame(-1, -1, 1'b0, 8'h5A, bits, busy_cyc, sent_cnt, glitches);
    check("t2_bits",      bits,     10'b1101001010);
    check("t2_busy_cyc",  busy_cyc, 160);
    check("t2_no_early_sent", sent_cnt, 0);
    check("t2_glitches",  glitches, 0);
    check("t2_sent_at_F", charSent, 1);
    check("t2_idle_at_F", txBusy,   0);
    check("t2_line_at_F", serialOut, 1);
    tick();
    check("t2_sent_1cyc", charSent, 0);

    // 3. Loads while busy are ignored
    tick();
    parallelIn = 8'h3C; loadChar = 1'b1;
    tick();
    run_frame(40, 100, 1'b0, 8'hFF, bits, busy_cyc, sent_cnt, glitches);
    check("t3_bits",      bits,     10'b1001111000);
    check("t3_no_early_sent", sent_cnt, 0);
    check("t3_glitches",  glitches, 0);
    check("t3_sent_at_F", charSent, 1);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (txBusy !== 1'b0 || charSent !== 1'b0 || serialOut !== 1'b1) extra++;
    end
    check("t3_no_second_frame", extra, 0);

    // 4. Back-to-back frames: 0x00 then 0xFF with loadChar held
    parallelIn = 8'h00; loadChar = 1'b1;
    tick();
    run_frame(-1, -1, 1'b1, 8'hFF, bits, busy_cyc, sent_cnt, glitches);
    check("t4_bits0",     bits,     10'b1000000000);
    check("t4_sent0",     charSent, 1);
    check("t4_no_gap_level", serialOut, 0);
    check("t4_no_gap_busy",  txBusy,    1);
    t_first = cyc;
    run_frame(-1, -1, 1'b0, 8'hFF, bits, busy_cyc, sent_cnt, glitches);
    check("t4_bits1",     bits,     10'b1111111110);
    check("t4_busy1",     busy_cyc, 160);
    check("t4_sent1",     charSent, 1);
    check("t4_sent_spacing", cyc - t_first, 160);
    check("t4_idle_after", txBusy, 0);
    tick();

    // 5. Reset mid-frame, then a clean frame
    parallelIn = 8'h55; loadChar = 1'b1;
    tick();
    loadChar = 1'b0;
    sent_cnt = 0;
    for (int c = 0; c < 75; c++) begin
      if (charSent === 1'b1) sent_cnt++;
      tick();
    end
    check("t5_pre_rst_level", serialOut, 0);
    rst = 1'b0;
    #1;
    check("t5_async_level", serialOut, 1);
    check("t5_async_busy",  txBusy,    0);
    check("t5_async_sent",  charSent,  0);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (charSent === 1'b1) sent_cnt++;
      check("t5_rst_level", serialOut, 1);
    end
    rst = 1'b1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (charSent === 1'b1 || serialOut !== 1'b1) sent_cnt++;
    end
    check("t5_abandoned_quiet", sent_cnt, 0);
    parallelIn = 8'h81; loadChar = 1'b1;
    tick();
    run_frame(-1, -1, 1'b0, 8'h00, bits, busy_cyc, sent_cnt, glitches);
    check("t5_bits",      bits,     10'b1100000010);
    check("t5_sent_at_F", charSent, 1);
    tick();

    // 6. DATA_BITS=7, CLKS_PER_BIT=4 variant, character 0x41
    parallelIn7 = 7'h41; loadChar7 = 1'b1;
    tick();
    loadChar7 = 1'b0; parallelIn7 = 7'h3E;
    bits7 = '0; busy_cyc = 0; sent_cnt = 0; glitches = 0; b7_start = 1'b1;
    for (int c = 0; c < 36; c++) begin
      if (c % 4 == 0) b7_start = serialOut7;
      else if (serialOut7 !== b7_start) glitches++;
      if (c % 4 == 2) bits7[c/4] = serialOut7;
      if (txBusy7 === 1'b1) busy_cyc++;
      if (charSent7 === 1'b1) sent_cnt++;
      tick();
    end
    check("t6_bits",      bits7,    9'b110000010);
    check("t6_busy_cyc",  busy_cyc, 36);
    check("t6_no_early_sent", sent_cnt, 0);
    check("t6_glitches",  glitches, 0);
    check("t6_sent_at_F", charSent7, 1);
    check("t6_idle_at_F", txBusy7,   0);
    tick();
    check("t6_sent_1cyc", charSent7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
